// File: rtl/music_sequencer.sv
// Multi-channel beat sequencer: a tempo divider steps a beat pointer into an external
// score table, and each channel's note code is decoded into a registered tone word.
module music_sequencer #(
  parameter int NUM_CH = 2,
  parameter int BEAT_W = 8,
  parameter int DIV_W  = 27,
  parameter int TONE_W = 32,
  parameter logic [TONE_W-1:0] REST_TONE = 100000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       pause,
  input  logic                       loop_en,
  input  logic [DIV_W-1:0]           beat_div,
  input  logic [BEAT_W-1:0]          last_beat,
  output logic [BEAT_W-1:0]          rom_addr,
  input  logic [NUM_CH*8-1:0]        rom_note,
  output logic [NUM_CH*TONE_W-1:0]   tone,
  output logic                       beat_tick,
  output logic                       playing,
  output logic                       paused,
  output logic                       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_lat;
  logic [DIV_W-1:0]  lat_in;
  logic              beat_end;

  // A divider of 0 would never produce a beat, so it behaves as 1.
  assign lat_in   = (beat_div == '0) ? DIV_W'(1) : beat_div;
  assign beat_end = (div_cnt == div_lat - DIV_W'(1));

  function automatic logic [TONE_W-1:0] decode(input logic [7:0] code);
    logic [9:0] base;
    logic       rest;
    logic [2:0] oct;
    base = 10'd0;
    rest = 1'b0;
    oct  = code[6:4];
    case (code[3:0])
      4'd1:    base = 10'd262;
      4'd2:    base = 10'd294;
      4'd3:    base = 10'd330;
      4'd4:    base = 10'd349;
      4'd5:    base = 10'd392;
      4'd6:    base = 10'd440;
      4'd7:    base = 10'd494;
      4'd8:    base = 10'd370;
      4'd9:    base = 10'd415;
      default: rest = 1'b1;
    endcase
    if (rest || oct == 3'd7)
      return REST_TONE;
    else if (oct >= 3'd3)
      return TONE_W'(base) << (oct - 3'd3);
    else
      return TONE_W'(base) >> (3'd3 - oct);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rom_addr  <= '0;
      div_cnt   <= '0;
      div_lat   <= DIV_W'(1);
      tone      <= {NUM_CH{REST_TONE}};
      beat_tick <= 1'b0;
      playing   <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
    end else begin
      beat_tick <= 1'b0;
      done      <= 1'b0;

      // Tone follows the state/address of the previous cycle.
      for (int c = 0; c < NUM_CH; c++) begin
        tone[TONE_W*c +: TONE_W] <= (state == PLAY) ? decode(rom_note[8*c +: 8]) : REST_TONE;
      end

      case (state)
        IDLE: begin
          if (!stop && start) begin
            state    <= PLAY;
            rom_addr <= '0;
            div_cnt  <= '0;
            div_lat  <= lat_in;
            playing  <= 1'b1;
            paused   <= 1'b0;
          end
        end

        PLAY: begin
          if (stop) begin
            state    <= IDLE;
            rom_addr <= '0;
            div_cnt  <= '0;
            playing  <= 1'b0;
            paused   <= 1'b0;
          end else if (start) begin
            rom_addr <= '0;
            div_cnt  <= '0;
            div_lat  <= lat_in;
          end else if (pause) begin
            state   <= PAUSE;
            playing <= 1'b0;
            paused  <= 1'b1;
          end else if (beat_end) begin
            div_cnt   <= '0;
            beat_tick <= 1'b1;
            if (rom_addr >= last_beat) begin
              rom_addr <= '0;
              if (!loop_en) begin
                state   <= IDLE;
                playing <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              rom_addr <= rom_addr + BEAT_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        PAUSE: begin
          if (stop) begin
            state    <= IDLE;
            rom_addr <= '0;
            div_cnt  <= '0;
            playing  <= 1'b0;
            paused   <= 1'b0;
          end else if (start) begin
            state    <= PLAY;
            rom_addr <= '0;
            div_cnt  <= '0;
            div_lat  <= lat_in;
            playing  <= 1'b1;
            paused   <= 1'b0;
          end else if (!pause) begin
            // Resume without counting this cycle, so the held div_cnt carries on unchanged.
            state   <= PLAY;
            playing <= 1'b1;
            paused  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          rom_addr <= '0;
          div_cnt  <= '0;
          playing  <= 1'b0;
          paused   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: a behavioural score table drives rom_note, tone words are
// checked through an expected queue, and beat timing/control sequences are stepped by hand.
module tb_music_sequencer;

  localparam int NUM_CH = 2;
  localparam int BEAT_W = 8;
  localparam int DIV_W  = 27;
  localparam int TONE_W = 32;
  localparam logic [31:0] REST = 32'd100000000;

  logic                      clk;
  logic                      rst_n;
  logic                      start;
  logic                      stop;
  logic                      pause;
  logic                      loop_en;
  logic [DIV_W-1:0]          beat_div;
  logic [BEAT_W-1:0]         last_beat;
  logic [BEAT_W-1:0]         rom_addr;
  logic [NUM_CH*8-1:0]       rom_note;
  logic [NUM_CH*TONE_W-1:0]  tone;
  logic                      beat_tick;
  logic                      playing;
  logic                      paused;
  logic                      done;

  music_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .beat_div  (beat_div),
    .last_beat (last_beat),
    .rom_addr  (rom_addr),
    .rom_note  (rom_note),
    .tone      (tone),
    .beat_tick (beat_tick),
    .playing   (playing),
    .paused    (paused),
    .done      (done)
  );

  // Combinational score table, one code array per channel.
  logic [7:0] score0 [256];
  logic [7:0] score1 [256];
  assign rom_note = {score1[rom_addr], score0[rom_addr]};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [7:0]  c0;
    logic [7:0]  c1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  vec_t tbl [8];

  logic [7:0]  t2_c0 [4];
  logic [7:0]  t2_c1 [4];
  logic [31:0] t2_e0 [4];
  logic [31:0] t2_e1 [4];

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_score();
    for (int i = 0; i < 256; i++) begin
      score0[i] = 8'h00;
      score1[i] = 8'h00;
    end
  endtask

  // Scoreboard
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic push_tone(input logic [31:0] t0, input logic [31:0] t1);
    exp_q.push_back({t1, t0});
  endtask

  task automatic pop_tone(input string name);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got tone 0x%0h expected nothing queued", name, tone);
    end else begin
      e = exp_q.pop_front();
      chk(name, tone, e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    beat_div = '0; last_beat = '0;
    clear_score();

    t2_c0 = '{8'h36, 8'h47, 8'h21, 8'h00};
    t2_e0 = '{32'd440, 32'd988, 32'd131, REST};
    t2_c1 = '{8'h68, 8'h05, 8'h73, 8'h44};
    t2_e1 = '{32'd2960, 32'd49, REST, 32'd698};

    tbl[0] = '{8'h0A, 8'h68, REST,      32'd2960};
    tbl[1] = '{8'h73, 8'h05, REST,      32'd49};
    tbl[2] = '{8'h68, 8'h0A, 32'd2960,  REST};
    tbl[3] = '{8'h05, 8'h36, 32'd49,    32'd440};
    tbl[4] = '{8'h21, 8'h11, 32'd131,   32'd65};
    tbl[5] = '{8'hB6, 8'h3F, 32'd440,   REST};
    tbl[6] = '{8'h59, 8'h12, 32'd1660,  32'd73};
    tbl[7] = '{8'h44, 8'h63, 32'd698,   32'd2640};

    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset_playing", playing, 0);
    chk("reset_paused", paused, 0);
    chk("reset_addr", rom_addr, 0);
    chk("reset_tone", tone, {REST, REST});
    chk("reset_tick", beat_tick, 0);
    chk("reset_done", done, 0);

    // One-shot song, 4 clocks per beat
    for (int i = 0; i < 4; i++) begin
      score0[i] = t2_c0[i];
      score1[i] = t2_c1[i];
    end
    beat_div = 4; last_beat = 3; loop_en = 1'b0;
    pulse_start();
    chk("os_playing", playing, 1);
    chk("os_start_tone", tone, {REST, REST});
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        chk("os_addr", rom_addr, b);
        chk("os_tick", beat_tick, (k == 0 && b != 0));
        push_tone(t2_e0[b], t2_e1[b]);
        step();
        pop_tone("os_tone");
      end
    end
    chk("os_done", done, 1);
    chk("os_end_tick", beat_tick, 1);
    chk("os_end_playing", playing, 0);
    chk("os_end_addr", rom_addr, 0);
    push_tone(REST, REST);
    step();
    pop_tone("os_idle_tone");
    chk("os_done_pulse", done, 0);

    // Looping song, three passes
    loop_en = 1'b1;
    pulse_start();
    for (int l = 0; l < 3; l++) begin
      for (int b = 0; b < 4; b++) begin
        for (int k = 0; k < 4; k++) begin
          chk("loop_addr", rom_addr, b);
          chk("loop_tick", beat_tick, (k == 0 && !(l == 0 && b == 0)));
          chk("loop_done", done, 0);
          push_tone(t2_e0[b], t2_e1[b]);
          step();
          pop_tone("loop_tone");
        end
      end
    end
    chk("loop_wrap_addr", rom_addr, 0);
    chk("loop_wrap_tick", beat_tick, 1);
    chk("loop_wrap_playing", playing, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_playing", playing, 0);
    chk("stop_done", done, 0);
    chk("stop_addr", rom_addr, 0);

    // Pause mid-beat, 8 clocks per beat
    beat_div = 8;
    pulse_start();
    repeat (8) step();
    chk("pz_beat1_addr", rom_addr, 1);
    chk("pz_beat1_tick", beat_tick, 1);
    repeat (5) step();
    pause = 1'b1;
    push_tone(t2_e0[1], t2_e1[1]);
    step();
    pop_tone("pz_enter_tone");
    chk("pz_paused", paused, 1);
    chk("pz_playing", playing, 0);
    push_tone(REST, REST);
    step();
    pop_tone("pz_rest_tone");
    repeat (18) step();
    chk("pz_hold_addr", rom_addr, 1);
    chk("pz_hold_paused", paused, 1);
    chk("pz_hold_tick", beat_tick, 0);
    pause = 1'b0;
    step();
    chk("pz_resume_playing", playing, 1);
    chk("pz_resume_paused", paused, 0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("pz_wait_addr", rom_addr, 1);
      chk("pz_wait_tick", beat_tick, 0);
    end
    step();
    chk("pz_beat2_addr", rom_addr, 2);
    chk("pz_beat2_tick", beat_tick, 1);

    // stop beats start; start beats pause
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk("ss_playing", playing, 0);
    chk("ss_addr", rom_addr, 0);
    chk("ss_done", done, 0);
    step();
    chk("ss_still_idle", playing, 0);
    beat_div = 8;
    pulse_start();
    pause = 1'b1;
    step();
    chk("rs_paused", paused, 1);
    beat_div = 3; start = 1'b1; pause = 1'b0;
    step();
    start = 1'b0;
    chk("rs_playing", playing, 1);
    chk("rs_paused_low", paused, 0);
    chk("rs_addr", rom_addr, 0);
    chk("rs_tick", beat_tick, 0);
    step(); step();
    chk("rs_wait_addr", rom_addr, 0);
    step();
    chk("rs_beat1_addr", rom_addr, 1);
    chk("rs_beat1_tick", beat_tick, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Decode table at one beat per clock (beat_div = 0)
    clear_score();
    for (int i = 0; i < 8; i++) begin
      score0[i] = tbl[i].c0;
      score1[i] = tbl[i].c1;
    end
    beat_div = 0; last_beat = 7; loop_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      chk("tbl_addr", rom_addr, i);
      chk("tbl_tick", beat_tick, (i != 0));
      push_tone(tbl[i].e0, tbl[i].e1);
      step();
      pop_tone("tbl_tone");
    end
    chk("tbl_done", done, 1);
    chk("tbl_playing", playing, 0);

    // Full-range pointer wrap
    clear_score();
    last_beat = 8'hFF; loop_en = 1'b1;
    pulse_start();
    repeat (255) step();
    chk("wrap_top_addr", rom_addr, 255);
    step();
    chk("wrap_addr", rom_addr, 0);
    chk("wrap_tick", beat_tick, 1);
    chk("wrap_playing", playing, 1);
    chk("wrap_done", done, 0);

    // Reset while playing
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rstp_playing", playing, 0);
    chk("rstp_addr", rom_addr, 0);
    chk("rstp_tone", tone, {REST, REST});
    chk("rstp_tick", beat_tick, 0);
    step();
    chk("rstp_idle", playing, 0);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
